me_mem_loader: RTL

Write-side companion to the motion-estimation control unit. It accepts a valid/ready pixel stream and writes one 16x16 reference block (256 pixels, row-major) into the RB memory. It then writes one 31x31 search window (961 pixels, row-major) into the SW memory. After the last write it issues a restart and run-enable window to the control unit.

---
 rtl/me_pkg.sv | 21 ++
 rtl/me_mem_loader.sv | 109 ++++++++++
 2 files changed

// File: rtl/me_pkg.sv
// Shared constants and types for the motion-estimation memory loader.
package me_pkg;

  localparam int unsigned DATA_WIDTH      = 8;
  localparam int unsigned RB_ROW_LEN      = 16;
  localparam int unsigned SW_ROW_LEN      = 31;
  localparam int unsigned RB_MEMORY_DEPTH = RB_ROW_LEN * RB_ROW_LEN;
  localparam int unsigned SW_MEMORY_DEPTH = SW_ROW_LEN * SW_ROW_LEN;
  localparam int unsigned RB_ADDR_WIDTH   = $clog2(RB_MEMORY_DEPTH);
  localparam int unsigned SW_ADDR_WIDTH   = $clog2(SW_MEMORY_DEPTH);
  localparam int unsigned CU_RUN_CYCLES   = 4096;
  localparam int unsigned RUN_CNT_WIDTH   = $clog2(CU_RUN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_RB = 2'd1,
    LOAD_SW = 2'd2,
    RUN     = 2'd3
  } loader_state_e;

endpackage

// File: rtl/me_mem_loader.sv
// Streams one reference block and one search window into their memories,
// then restarts and enables the motion-estimation control unit.
module me_mem_loader
  import me_pkg::*;
(
  input  logic                     in_clk,
  input  logic                     in_rst,
  input  logic                     in_start,
  input  logic                     in_abort,
  input  logic [DATA_WIDTH-1:0]    in_pix_data,
  input  logic                     in_pix_valid,
  output logic                     out_pix_ready,
  output logic                     out_rb_write_ena,
  output logic [RB_ADDR_WIDTH-1:0] out_rb_write_addr,
  output logic [DATA_WIDTH-1:0]    out_rb_write_data,
  output logic                     out_sw_write_ena,
  output logic [SW_ADDR_WIDTH-1:0] out_sw_write_addr,
  output logic [DATA_WIDTH-1:0]    out_sw_write_data,
  output logic                     out_busy,
  output logic                     out_load_done,
  output logic                     out_cu_rst,
  output logic                     out_cu_ena
);

  loader_state_e state, state_next;

  logic [RB_ADDR_WIDTH-1:0] rb_cnt;
  logic [SW_ADDR_WIDTH-1:0] sw_cnt;
  logic [RUN_CNT_WIDTH-1:0] run_cnt;

  logic xfer, rb_last, sw_last, run_last, rb_entry;

  // Ready is combinational so an aborting cycle can never accept a beat.
  always_comb begin
    out_pix_ready = ((state == LOAD_RB) || (state == LOAD_SW)) && !in_abort;
    xfer          = in_pix_valid && out_pix_ready;
    rb_last       = (rb_cnt == RB_ADDR_WIDTH'(RB_MEMORY_DEPTH - 1));
    sw_last       = (sw_cnt == SW_ADDR_WIDTH'(SW_MEMORY_DEPTH - 1));
    run_last      = out_cu_ena && (run_cnt == RUN_CNT_WIDTH'(CU_RUN_CYCLES - 1));
    rb_entry      = (state == IDLE) && (state_next == LOAD_RB);
  end

  always_comb begin
    state_next = state;
    if (in_abort) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (in_start)         state_next = LOAD_RB;
        LOAD_RB: if (xfer && rb_last)  state_next = LOAD_SW;
        LOAD_SW: if (xfer && sw_last)  state_next = RUN;
        RUN:     if (run_last)         state_next = IDLE;
        default:                       state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) state <= IDLE;
    else        state <= state_next;
  end

  // Address counters, write ports, handshake pulses and run window.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      rb_cnt            <= '0;
      sw_cnt            <= '0;
      run_cnt           <= '0;
      out_rb_write_ena  <= 1'b0;
      out_rb_write_addr <= '0;
      out_rb_write_data <= '0;
      out_sw_write_ena  <= 1'b0;
      out_sw_write_addr <= '0;
      out_sw_write_data <= '0;
      out_busy          <= 1'b0;
      out_load_done     <= 1'b0;
      out_cu_rst        <= 1'b0;
      out_cu_ena        <= 1'b0;
    end else begin
      out_rb_write_ena <= (state == LOAD_RB) && xfer;
      out_sw_write_ena <= (state == LOAD_SW) && xfer;
      out_load_done    <= (state == LOAD_SW) && xfer && sw_last;
      out_cu_rst       <= (state == LOAD_SW) && xfer && sw_last;
      out_cu_ena       <= (state == RUN) && !in_abort && !run_last;
      out_busy         <= (state_next != IDLE);

      if (rb_entry) begin
        rb_cnt <= '0;
        sw_cnt <= '0;
      end else begin
        if ((state == LOAD_RB) && xfer && !rb_last) rb_cnt <= rb_cnt + RB_ADDR_WIDTH'(1);
        if ((state == LOAD_SW) && xfer && !sw_last) sw_cnt <= sw_cnt + SW_ADDR_WIDTH'(1);
      end

      if ((state == LOAD_RB) && xfer) begin
        out_rb_write_addr <= rb_cnt;
        out_rb_write_data <= in_pix_data;
      end
      if ((state == LOAD_SW) && xfer) begin
        out_sw_write_addr <= sw_cnt;
        out_sw_write_data <= in_pix_data;
      end

      if (state != RUN)    run_cnt <= '0;
      else if (out_cu_ena) run_cnt <= run_cnt + RUN_CNT_WIDTH'(1);
    end
  end

endmodule
